// File: rtl/hazard_ctrl_p_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Control patterns are {PC_Write,IF_ID_Write,ID_EX_Write,IF_ID_Flush,ID_EX_Flush,EX_MEM_Bubble}.
package hazard_ctrl_p_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_t;

  // All-zero control word loaded into ID/EX and EX/MEM as a bubble.
  localparam int unsigned PIPE_CTRL_W = 10;
  localparam logic [PIPE_CTRL_W-1:0] PIPE_NOP_CTRL = '0;

  typedef struct packed {
    logic pcWrite;
    logic ifIdWrite;
    logic idExWrite;
    logic ifIdFlush;
    logic idExFlush;
    logic exMemBubble;
  } ctrl_t;

  localparam ctrl_t CTRL_DEFAULT = 6'b111_000;
  localparam ctrl_t CTRL_RESET   = 6'b000_111;
  localparam ctrl_t CTRL_BRANCH  = 6'b111_110;
  localparam ctrl_t CTRL_MD      = 6'b000_001;
  localparam ctrl_t CTRL_LU      = 6'b001_010;

  function automatic logic loadUse(
    input logic       memRead,
    input logic [4:0] rd,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       useRt
  );
    return memRead && (rd != 5'd0) &&
           ((rd == rs) || (useRt && (rd == rt)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_p_sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
// Holds at all-ones instead of wrapping.
module sat_counter_p #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled cycles, stop at the maximum value.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl_p.sv
// Hazard and stall controller: load-use bubbles, branch flushes,
// mul/div freeze with timeout, and a stall-cycle counter.
module hazard_ctrl_p
  import hazard_ctrl_p_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemRead_ex,
  input  logic [4:0]       RegWriteAddr_ex,
  input  logic [4:0]       RsAddr_id,
  input  logic [4:0]       RtAddr_id,
  input  logic             UseRt_id,
  input  logic             BranchTaken_ex,
  input  logic             MdStart_ex,
  input  logic             MdDone,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Bubble,
  output logic             MdTimeout,
  output logic [CNT_W-1:0] StallCount
);

  localparam logic [7:0] MdLast = 8'(MD_TIMEOUT - 1);

  state_t     state;
  state_t     stateNext;
  logic [7:0] mdcnt;
  logic [7:0] mdcntNext;
  logic       timeoutNext;
  ctrl_t      ctrl;
  logic       lu;

  assign lu = loadUse(MemRead_ex, RegWriteAddr_ex,
                      RsAddr_id, RtAddr_id, UseRt_id);

  // Next state and combinational pipeline controls.
  always_comb begin
    ctrl        = CTRL_DEFAULT;
    stateNext   = state;
    mdcntNext   = mdcnt;
    timeoutNext = 1'b0;
    if (rst) begin
      ctrl      = CTRL_RESET;
      stateNext = ST_RUN;
      mdcntNext = 8'd0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (BranchTaken_ex) begin
            ctrl = CTRL_BRANCH;
          end else if (MdStart_ex) begin
            if (!MdDone) begin
              ctrl      = CTRL_MD;
              stateNext = ST_MD_WAIT;
              mdcntNext = 8'd1;
            end
          end else if (lu) begin
            ctrl = CTRL_LU;
          end
        end
        ST_MD_WAIT: begin
          if (MdDone) begin
            stateNext = ST_RUN;
            mdcntNext = 8'd0;
          end else if (mdcnt == MdLast) begin
            stateNext   = ST_RUN;
            mdcntNext   = 8'd0;
            timeoutNext = 1'b1;
          end else begin
            ctrl      = CTRL_MD;
            mdcntNext = mdcnt + 8'd1;
          end
        end
        default: begin
          stateNext = ST_RUN;
          mdcntNext = 8'd0;
        end
      endcase
    end
  end

  // State, wait counter and timeout pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      mdcnt     <= 8'd0;
      MdTimeout <= 1'b0;
    end else begin
      state     <= stateNext;
      mdcnt     <= mdcntNext;
      MdTimeout <= timeoutNext;
    end
  end

  assign PC_Write      = ctrl.pcWrite;
  assign IF_ID_Write   = ctrl.ifIdWrite;
  assign ID_EX_Write   = ctrl.idExWrite;
  assign IF_ID_Flush   = ctrl.ifIdFlush;
  assign ID_EX_Flush   = ctrl.idExFlush;
  assign EX_MEM_Bubble = ctrl.exMemBubble;

  sat_counter_p #(
    .W(CNT_W)
  ) uStallCnt (
    .clk  (clk),
    .clr  (rst),
    .en   (!ctrl.pcWrite && !rst),
    .count(StallCount)
  );

endmodule

// File: tb/tb_hazard_ctrl_p.sv
// Self-checking bench for hazard_ctrl_p: directed scenarios
// followed by random traffic against a behavioural model.
module tb_hazard_ctrl_p;

  localparam int TO    = 8;
  localparam int CW    = 4;
  localparam int SMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          memRead;
  logic [4:0]    rd;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic          useRt;
  logic          br;
  logic          mdStart;
  logic          mdDone;
  logic          pcW;
  logic          ifIdW;
  logic          idExW;
  logic          ifIdF;
  logic          idExF;
  logic          exMemB;
  logic          mdTo;
  logic [CW-1:0] stallCnt;

  int checks = 0;
  int errors = 0;

  // model state
  bit       mWait;
  int       mSince;
  int       mStall;
  bit       mTo;
  bit [5:0] mExp;

  always #5 clk = ~clk;

  hazard_ctrl_p #(
    .MD_TIMEOUT(TO),
    .CNT_W     (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .MemRead_ex     (memRead),
    .RegWriteAddr_ex(rd),
    .RsAddr_id      (rs),
    .RtAddr_id      (rt),
    .UseRt_id       (useRt),
    .BranchTaken_ex (br),
    .MdStart_ex     (mdStart),
    .MdDone         (mdDone),
    .PC_Write       (pcW),
    .IF_ID_Write    (ifIdW),
    .ID_EX_Write    (idExW),
    .IF_ID_Flush    (ifIdF),
    .ID_EX_Flush    (idExF),
    .EX_MEM_Bubble  (exMemB),
    .MdTimeout      (mdTo),
    .StallCount     (stallCnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setIn(input bit mr, input int d, input int s,
                       input int t, input bit ur, input bit b,
                       input bit ms, input bit md);
    memRead = mr;
    rd      = 5'(d);
    rs      = 5'(s);
    rt      = 5'(t);
    useRt   = ur;
    br      = b;
    mdStart = ms;
    mdDone  = md;
  endtask

  // Expected controls {PC,IFID_W,IDEX_W,IFID_F,IDEX_F,EXMEM_B}.
  function automatic bit [5:0] expCtrl();
    bit hit;
    hit = memRead && rd != 0 &&
          (rd == rs || (useRt && rd == rt));
    if (rst) return 6'b000111;
    if (mWait) begin
      if (mdDone || mSince == TO - 1) return 6'b111000;
      return 6'b000001;
    end
    if (br) return 6'b111110;
    if (mdStart) return mdDone ? 6'b111000 : 6'b000001;
    if (hit) return 6'b001010;
    return 6'b111000;
  endfunction

  task automatic modelEdge();
    if (rst) begin
      mWait  = 0;
      mSince = 0;
      mStall = 0;
      mTo    = 0;
      return;
    end
    if (!mExp[5] && mStall < SMAX) mStall++;
    mTo = 0;
    if (mWait) begin
      if (mdDone) begin
        mWait = 0;
      end else if (mSince == TO - 1) begin
        mWait = 0;
        mTo   = 1;
      end else begin
        mSince++;
      end
    end else if (!br && mdStart && !mdDone) begin
      mWait  = 1;
      mSince = 1;
    end
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    mExp = expCtrl();
    chk({tag, ".ctrl"},
        {26'd0, pcW, ifIdW, idExW, ifIdF, idExF, exMemB},
        {26'd0, mExp});
    chk({tag, ".stall"}, {28'd0, stallCnt}, 32'(mStall));
    chk({tag, ".mdto"}, {31'd0, mdTo}, {31'd0, mTo});
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("rst");
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    mWait = 0; mSince = 0; mStall = 0; mTo = 0;
    doReset();

    // load-use on rs
    setIn(1, 5, 5, 0, 0, 0, 0, 0);
    cycle("lu");
    setIn(0, 5, 5, 0, 0, 0, 0, 0);
    cycle("lu.next");
    chk("lu.cnt", {28'd0, stallCnt}, 32'd1);

    // no hazard: $0 and unused rt
    setIn(1, 0, 0, 0, 1, 0, 0, 0);
    cycle("lu.r0");
    setIn(1, 5, 1, 5, 0, 0, 0, 0);
    cycle("lu.nort");
    setIn(1, 5, 1, 5, 1, 0, 0, 0);
    cycle("lu.rt");

    // branch beats load-use
    setIn(1, 5, 5, 0, 0, 1, 0, 0);
    cycle("br");
    chk("br.pc", {31'd0, pcW}, 32'd1);

    // mul/div finishing four cycles after start
    doReset();
    setIn(0, 0, 0, 0, 0, 0, 1, 0);
    cycle("md.start");
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("md.wait");
    setIn(0, 0, 0, 0, 0, 0, 0, 1);
    cycle("md.done");
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("md.after");
    chk("md.cnt", {28'd0, stallCnt}, 32'd4);

    // single-cycle mul/div
    setIn(0, 0, 0, 0, 0, 0, 1, 1);
    cycle("md.single");

    // timeout, then restart
    doReset();
    setIn(0, 0, 0, 0, 0, 0, 1, 0);
    cycle("to.start");
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) cycle("to.wait");
    cycle("to.pulse");
    chk("to.cnt", {28'd0, stallCnt}, 32'd7);
    cycle("to.clear");
    setIn(0, 0, 0, 0, 0, 0, 1, 0);
    cycle("to.restart");
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("to.rwait");
    setIn(0, 0, 0, 0, 0, 0, 0, 1);
    cycle("to.rdone");

    // reset during wait
    setIn(0, 0, 0, 0, 0, 0, 1, 0);
    cycle("rw.start");
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("rw.wait");
    doReset();
    cycle("rw.after");
    chk("rw.cnt", {28'd0, stallCnt}, 32'd0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      setIn($urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 7) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
